cdf53_row_stream: RTL and testbench

//  Streaming, parametrised row wavelet transformer (successor to the one-shot row_to_cdf).

---
 rtl/cdf53_row_stream_pkg.sv | 19 +
 rtl/cdf53_row_stream_lift.sv | 57 +++++
 rtl/cdf53_row_stream.sv | 157 +++++++++++++++
 tb/tb_cdf53_row_stream.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdf53_row_stream_pkg.sv
// Shared types for the row wavelet datapath: transform mode, row FSM states and coefficient width.
package wavelet_pkg;

    typedef enum logic {
        WL_CDF53 = 1'b0,
        WL_HAAR  = 1'b1
    } wl_mode_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } row_state_e;

    // Two extra bits cover the sign and the one-bit growth of the predict step.
    function automatic int coef_w(input int data_w);
        return data_w + 2;
    endfunction

endpackage

// File: rtl/cdf53_row_stream_lift.sv
// Combinational lifting datapath: predict (detail) and update (approximation) for CDF 5/3 or Haar.
module cdf53_lift_core
    import wavelet_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IW     = DATA_W + 2
) (
    input  logic [DATA_W-1:0]    x_even,
    input  logic [DATA_W-1:0]    x_odd,
    input  logic [DATA_W-1:0]    x_next,
    input  logic signed [IW-1:0] d_prev,
    input  logic                 first_pair,
    input  logic                 mode,
    output logic signed [IW-1:0] s,
    output logic signed [IW-1:0] d
);

    logic signed [IW-1:0] ev_s;
    logic signed [IW-1:0] od_s;
    logic signed [IW-1:0] nx_s;
    logic signed [IW-1:0] sum_s;
    logic signed [IW-1:0] pred_s;
    logic signed [IW-1:0] d53_s;
    logic signed [IW-1:0] dh_s;
    logic signed [IW-1:0] upd_s;
    logic signed [IW+1:0] dp_w_s;
    logic signed [IW+1:0] dc_w_s;
    logic signed [IW+1:0] upd_w_s;

    assign ev_s = $signed({2'b00, x_even});
    assign od_s = $signed({2'b00, x_odd});
    assign nx_s = $signed({2'b00, x_next});

    // Predict/update arithmetic; the update sum is widened so d_prev+d+2 cannot wrap.
    always_comb begin
        sum_s  = ev_s + nx_s;
        pred_s = $signed({sum_s[IW-1], sum_s[IW-1:1]});
        d53_s  = od_s - pred_s;
        dh_s   = od_s - ev_s;
        dc_w_s = {{2{d53_s[IW-1]}}, d53_s};
        if (first_pair) begin
            dp_w_s = dc_w_s;
        end else begin
            dp_w_s = {{2{d_prev[IW-1]}}, d_prev};
        end
        upd_w_s = dp_w_s + dc_w_s + $signed({{IW{1'b0}}, 2'b10});
        upd_s   = upd_w_s[IW+1:2];
        if (mode == WL_HAAR) begin
            d = dh_s;
            s = ev_s + $signed({dh_s[IW-1], dh_s[IW-1:1]});
        end else begin
            d = d53_s;
            s = ev_s + upd_s;
        end
    end

endmodule

// File: rtl/cdf53_row_stream.sv
// Streaming row wavelet transformer: one pixel in per handshake, one (s, d) pair out per pixel pair.
module cdf53_row_stream
    import wavelet_pkg::*;
#(
    parameter int LENGTH = 256,
    parameter int DATA_W = 8,
    parameter int COEF_W = coef_w(DATA_W)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mode,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [COEF_W-1:0] s_out,
    output logic [COEF_W-1:0] d_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy
);

    localparam int IW = DATA_W + 2;
    localparam int CW = $clog2(LENGTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(LENGTH - 1);

    row_state_e           state_r;
    wl_mode_e             mode_r;
    logic [CW-1:0]        cnt_r;
    logic [DATA_W-1:0]    x_even_r;
    logic [DATA_W-1:0]    x_odd_r;
    logic signed [IW-1:0] d_prev_r;

    logic                 accept_s;
    logic                 take_last_s;
    logic                 load_s;
    logic                 last_s;
    logic                 first_pair_s;
    logic [DATA_W-1:0]    core_odd_s;
    logic [DATA_W-1:0]    core_next_s;
    logic signed [IW-1:0] core_s_s;
    logic signed [IW-1:0] core_d_s;

    assign in_ready = (state_r == ST_RUN) && (!out_valid || out_ready);

    cdf53_lift_core #(
        .DATA_W (DATA_W),
        .IW     (IW)
    ) u_lift (
        .x_even     (x_even_r),
        .x_odd      (core_odd_s),
        .x_next     (core_next_s),
        .d_prev     (d_prev_r),
        .first_pair (first_pair_s),
        .mode       (mode_r),
        .s          (core_s_s),
        .d          (core_d_s)
    );

    // Operand selection and pair-load decision; FLUSH mirrors x[LENGTH-2] as the missing right neighbour.
    always_comb begin
        accept_s     = in_valid && in_ready;
        take_last_s  = out_valid && out_last && out_ready;
        core_odd_s   = x_odd_r;
        core_next_s  = in_data;
        first_pair_s = 1'b0;
        load_s       = 1'b0;
        last_s       = 1'b0;
        if (mode_r == WL_HAAR) begin
            core_odd_s = in_data;
        end else begin
            core_odd_s = x_odd_r;
        end
        if (state_r == ST_FLUSH) begin
            core_next_s = x_even_r;
            load_s      = !(out_valid && out_last) && (!out_valid || out_ready);
            last_s      = 1'b1;
        end else begin
            core_next_s  = in_data;
            first_pair_s = (cnt_r == CW'(2));
            if (mode_r == WL_HAAR) begin
                load_s = accept_s && cnt_r[0];
                last_s = (cnt_r == LAST_IDX);
            end else begin
                load_s = accept_s && !cnt_r[0] && (cnt_r != '0);
                last_s = 1'b0;
            end
        end
    end

    // Row FSM, sample history and the registered output pair.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= ST_RUN;
            mode_r    <= WL_CDF53;
            cnt_r     <= '0;
            x_even_r  <= '0;
            x_odd_r   <= '0;
            d_prev_r  <= '0;
            s_out     <= '0;
            d_out     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (accept_s) begin
                        if (cnt_r == LAST_IDX) begin
                            cnt_r <= '0;
                            if (mode_r == WL_CDF53) begin
                                state_r <= ST_FLUSH;
                            end
                        end else begin
                            cnt_r <= cnt_r + CW'(1);
                        end
                        if (cnt_r == '0) begin
                            x_even_r <= in_data;
                            mode_r   <= wl_mode_e'(mode);
                        end else if (cnt_r[0]) begin
                            x_odd_r <= in_data;
                        end else begin
                            x_even_r <= in_data;
                            d_prev_r <= core_d_s;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (take_last_s) begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r <= ST_RUN;
                end
            endcase

            if (load_s) begin
                s_out     <= COEF_W'(core_s_s);
                d_out     <= COEF_W'(core_d_s);
                out_valid <= 1'b1;
                out_last  <= last_s;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            // A new row can start on the same edge the previous row's last pair leaves.
            if (accept_s && (state_r == ST_RUN) && (cnt_r == '0)) begin
                busy <= 1'b1;
            end else if (take_last_s) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdf53_row_stream.sv
// Directed bench for cdf53_row_stream with LENGTH=8, DATA_W=8 and hand-computed coefficient pairs.
module tb_cdf53_row_stream;

    localparam int LENGTH = 8;
    localparam int DATA_W = 8;
    localparam int COEF_W = 10;

    logic              clk = 1'b0;
    logic              resetn;
    logic              mode;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [COEF_W-1:0] s_out;
    logic [COEF_W-1:0] d_out;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int q_s[$];
    int q_d[$];
    int q_l[$];
    int q_acc[$];
    int ramp[8];

    cdf53_row_stream #(
        .LENGTH (LENGTH),
        .DATA_W (DATA_W),
        .COEF_W (COEF_W)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mode      (mode),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s_out     (s_out),
        .d_out     (d_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Record every accepted sample (by cycle) and every pair taken downstream.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (resetn && in_valid && in_ready) q_acc.push_back(cyc);
        if (resetn && out_valid && out_ready) begin
            q_s.push_back($signed(s_out));
            q_d.push_back($signed(d_out));
            q_l.push_back(int'(out_last));
        end
    end

    task automatic clear_q();
        q_s.delete();
        q_d.delete();
        q_l.delete();
        q_acc.delete();
    endtask

    task automatic drive_row(input int px[8], input logic m, input int n, input bit flip);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 300) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'(px[i]);
            mode     = (flip && i > 0) ? ~m : m;
            if (in_ready) i++;
            guard++;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_pairs(input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (q_s.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; mode = 1'b0; in_data = '0;
        #2;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (out_last !== 1'b0) $display("FAIL reset_out_last: got %b want 0", out_last); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (s_out !== 10'd0 || d_out !== 10'd0) $display("FAIL reset_coef: got s=%0d d=%0d want 0 0", s_out, d_out); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ramp_cdf();
        int es[4] = '{0, 2, 4, 6};
        int ed[4] = '{0, 0, 0, 1};
        bit ok;
        clear_q();
        drive_row(ramp, 1'b0, 8, 1'b0);
        total++; if (busy !== 1'b1) $display("FAIL cdf_busy_mid: got %b want 1", busy); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL cdf_flush_in_ready: got %b want 0", in_ready); else passed++;
        wait_pairs(4, ok);
        total++; if (!ok) $display("FAIL cdf_timeout: got %0d pairs want 4", q_s.size()); else passed++;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (q_s[k] !== es[k] || q_d[k] !== ed[k] || q_l[k] !== int'(k == 3))
                $display("FAIL cdf_ramp_pair%0d: got (%0d,%0d,last=%0d) want (%0d,%0d,last=%0d)", k, q_s[k], q_d[k], q_l[k], es[k], ed[k], int'(k == 3));
            else passed++;
        end
        total++; if (busy !== 1'b0 || in_ready !== 1'b1) $display("FAIL cdf_idle: got busy=%b in_ready=%b want 0 1", busy, in_ready); else passed++;
    endtask

    task automatic test_ramp_haar();
        int es[4] = '{0, 2, 4, 6};
        bit ok;
        clear_q();
        drive_row(ramp, 1'b1, 8, 1'b1);
        total++; if (out_last !== 1'b1 || busy !== 1'b1) $display("FAIL haar_last_pending: got last=%b busy=%b want 1 1", out_last, busy); else passed++;
        wait_pairs(4, ok);
        total++; if (!ok) $display("FAIL haar_timeout: got %0d pairs want 4", q_s.size()); else passed++;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (q_s[k] !== es[k] || q_d[k] !== 1 || q_l[k] !== int'(k == 3))
                $display("FAIL haar_ramp_pair%0d: got (%0d,%0d,last=%0d) want (%0d,1,last=%0d)", k, q_s[k], q_d[k], q_l[k], es[k], int'(k == 3));
            else passed++;
        end
    endtask

    task automatic test_alternating();
        int px[8] = '{255, 0, 255, 0, 255, 0, 255, 0};
        bit ok;
        clear_q();
        drive_row(px, 1'b0, 8, 1'b0);
        wait_pairs(4, ok);
        total++; if (!ok) $display("FAIL alt_timeout: got %0d pairs want 4", q_s.size()); else passed++;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (q_s[k] !== 128 || q_d[k] !== -255)
                $display("FAIL alt_pair%0d: got (%0d,%0d) want (128,-255)", k, q_s[k], q_d[k]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int flat[8] = '{100, 100, 100, 100, 100, 100, 100, 100};
        int es[8] = '{100, 100, 100, 100, 0, 2, 4, 6};
        int ed[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
        bit ok;
        clear_q();
        drive_row(flat, 1'b0, 8, 1'b0);
        drive_row(ramp, 1'b0, 8, 1'b0);
        wait_pairs(8, ok);
        total++; if (!ok) $display("FAIL b2b_timeout: got %0d pairs want 8", q_s.size()); else passed++;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (q_s[k] !== es[k] || q_d[k] !== ed[k] || q_l[k] !== int'(k == 3 || k == 7))
                $display("FAIL b2b_pair%0d: got (%0d,%0d,last=%0d) want (%0d,%0d,last=%0d)", k, q_s[k], q_d[k], q_l[k], es[k], ed[k], int'(k == 3 || k == 7));
            else passed++;
        end
        total++;
        if (q_acc.size() < 9 || q_acc[8] - q_acc[7] !== 3)
            $display("FAIL b2b_gap: got %0d cycles want 3", (q_acc.size() < 9) ? -1 : q_acc[8] - q_acc[7]);
        else passed++;
    endtask

    task automatic test_backpressure();
        int px[8] = '{10, 11, 12, 13, 14, 15, 16, 17};
        int es[4] = '{10, 12, 14, 16};
        int ed[4] = '{0, 0, 0, 1};
        bit ok;
        clear_q();
        fork
            drive_row(px, 1'b0, 8, 1'b0);
            begin
                for (int c = 0; c < 50; c++) begin
                    @(posedge clk);
                    #1;
                    if (out_valid) break;
                end
                out_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_c%0d: got %b want 0", c, in_ready); else passed++;
                    total++; if (out_valid !== 1'b1) $display("FAIL bp_valid_c%0d: got %b want 1", c, out_valid); else passed++;
                    total++;
                    if ($signed(s_out) !== 10 || $signed(d_out) !== 0)
                        $display("FAIL bp_hold_c%0d: got (%0d,%0d) want (10,0)", c, $signed(s_out), $signed(d_out));
                    else passed++;
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_pairs(4, ok);
        total++; if (!ok) $display("FAIL bp_timeout: got %0d pairs want 4", q_s.size()); else passed++;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (q_s[k] !== es[k] || q_d[k] !== ed[k] || q_l[k] !== int'(k == 3))
                $display("FAIL bp_pair%0d: got (%0d,%0d,last=%0d) want (%0d,%0d,last=%0d)", k, q_s[k], q_d[k], q_l[k], es[k], ed[k], int'(k == 3));
            else passed++;
        end
    endtask

    task automatic test_reset_midrow();
        int px[8] = '{50, 60, 70, 0, 0, 0, 0, 0};
        int es[4] = '{0, 2, 4, 6};
        int ed[4] = '{0, 0, 0, 1};
        bit ok;
        out_ready = 1'b0;
        drive_row(px, 1'b0, 3, 1'b0);
        total++;
        if (out_valid !== 1'b1 || $signed(s_out) !== 50 || $signed(d_out) !== 0)
            $display("FAIL rst_pre_pair: got valid=%b (%0d,%0d) want 1 (50,0)", out_valid, $signed(s_out), $signed(d_out));
        else passed++;
        resetn = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rst_mid_flags: got valid=%b busy=%b want 0 0", out_valid, busy); else passed++;
        total++; if (s_out !== 10'd0 || d_out !== 10'd0) $display("FAIL rst_mid_coef: got (%0d,%0d) want (0,0)", s_out, d_out); else passed++;
        out_ready = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        clear_q();
        drive_row(ramp, 1'b0, 8, 1'b0);
        wait_pairs(4, ok);
        total++; if (!ok) $display("FAIL rst_timeout: got %0d pairs want 4", q_s.size()); else passed++;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (q_s[k] !== es[k] || q_d[k] !== ed[k] || q_l[k] !== int'(k == 3))
                $display("FAIL rst_ramp_pair%0d: got (%0d,%0d,last=%0d) want (%0d,%0d,last=%0d)", k, q_s[k], q_d[k], q_l[k], es[k], ed[k], int'(k == 3));
            else passed++;
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) ramp[i] = i;
        test_reset();
        test_ramp_cdf();
        test_ramp_haar();
        test_alternating();
        test_back_to_back();
        test_backpressure();
        test_reset_midrow();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
